reg_alu_datapath: RTL and testbench

Register-file-plus-ALU slice of the 16-bit multicycle datapath. Holds sixteen 16-bit general registers and three operand latches A, B and C. Feeds selectable operands, including a constant 1, into a combinational ALU that produces a result and a zero flag. Sits between instruction decode (which drives register numbers and control) and the writeback/memory stages (which consume ALUOut).

---
 rtl/reg_alu_datapath.sv | 119 +++++++++++
 tb/tb_reg_alu_datapath.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_alu_datapath.sv
// Register-file-plus-ALU slice of the 16-bit multicycle datapath: sixteen
// general registers, operand latches A/B/C and a combinational ALU with zero flag.
module reg_alu_datapath (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        RegWrite,
   input  logic [3:0]  Read1,
   input  logic [3:0]  Read2,
   input  logic [3:0]  WriteReg,
   input  logic [15:0] WriteData,
   input  logic        Write,
   input  logic [1:0]  ALUsrcA,
   input  logic [1:0]  ALUsrcB,
   input  logic [3:0]  ALUct1,
   input  logic        Flip,
   output logic [15:0] OA,
   output logic [15:0] OB,
   output logic [15:0] OC,
   output logic [15:0] ALUOut,
   output logic        Zero
);

   localparam logic [3:0] OP_AND = 4'd0;
   localparam logic [3:0] OP_OR  = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_XOR = 4'd3;
   localparam logic [3:0] OP_SLL = 4'd4;
   localparam logic [3:0] OP_SRL = 4'd5;
   localparam logic [3:0] OP_SUB = 4'd6;
   localparam logic [3:0] OP_SLT = 4'd7;
   localparam logic [3:0] OP_NOR = 4'd12;

   logic [15:0] r_regs [16];
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic [15:0] r_c;

   logic [15:0] w_data1;
   logic [15:0] w_data2;
   logic [15:0] w_data3;
   logic [15:0] w_x;
   logic [15:0] w_y;
   logic [15:0] w_left;
   logic [15:0] w_right;
   logic [15:0] w_result;

   // reg[0] is forced to read zero regardless of storage contents.
   assign w_data1 = (Read1    == 4'd0) ? 16'h0000 : r_regs[Read1];
   assign w_data2 = (Read2    == 4'd0) ? 16'h0000 : r_regs[Read2];
   assign w_data3 = (WriteReg == 4'd0) ? 16'h0000 : r_regs[WriteReg];

   // Latches sample the pre-edge register contents, so a same-edge write
   // to the addressed register becomes visible only on a later load.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         for (int i = 0; i < 16; i++) begin
            r_regs[i] <= 16'h0000;
         end
         r_a <= 16'h0000;
         r_b <= 16'h0000;
         r_c <= 16'h0000;
      end else begin
         if (RegWrite && (WriteReg != 4'd0)) begin
            r_regs[WriteReg] <= WriteData;
         end
         if (Write) begin
            r_a <= w_data1;
            r_b <= w_data2;
            r_c <= w_data3;
         end
      end
   end

   always_comb begin
      w_x = r_a;
      unique case (ALUsrcA)
         2'd0:    w_x = r_a;
         2'd1:    w_x = r_b;
         2'd2:    w_x = r_c;
         default: w_x = 16'h0001;
      endcase
   end

   always_comb begin
      w_y = r_a;
      unique case (ALUsrcB)
         2'd0:    w_y = r_a;
         2'd1:    w_y = 16'h0001;
         2'd2:    w_y = r_c;
         default: w_y = 16'h0000;
      endcase
   end

   assign w_left  = Flip ? w_y : w_x;
   assign w_right = Flip ? w_x : w_y;

   always_comb begin
      w_result = 16'h0000;
      case (ALUct1)
         OP_AND:  w_result = w_left & w_right;
         OP_OR:   w_result = w_left | w_right;
         OP_ADD:  w_result = w_left + w_right;
         OP_XOR:  w_result = w_left ^ w_right;
         OP_SLL:  w_result = w_left << w_right[3:0];
         OP_SRL:  w_result = w_left >> w_right[3:0];
         OP_SUB:  w_result = w_left - w_right;
         OP_SLT:  w_result = ($signed(w_left) < $signed(w_right)) ? 16'h0001 : 16'h0000;
         OP_NOR:  w_result = ~(w_left | w_right);
         default: w_result = 16'h0000;
      endcase
   end

   assign OA     = r_a;
   assign OB     = r_b;
   assign OC     = r_c;
   assign ALUOut = w_result;
   assign Zero   = (w_result == 16'h0000);

endmodule

// File: tb/tb_reg_alu_datapath.sv
// Directed plus randomized bench for reg_alu_datapath with an expected-value
// queue popped at each observation point.
module tb_reg_alu_datapath;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        RegWrite;
   logic [3:0]  Read1;
   logic [3:0]  Read2;
   logic [3:0]  WriteReg;
   logic [15:0] WriteData;
   logic        Write;
   logic [1:0]  ALUsrcA;
   logic [1:0]  ALUsrcB;
   logic [3:0]  ALUct1;
   logic        Flip;
   logic [15:0] OA;
   logic [15:0] OB;
   logic [15:0] OC;
   logic [15:0] ALUOut;
   logic        Zero;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];
   string       tag_q[$];

   reg_alu_datapath dut (
      .CLK(CLK), .Reset(Reset), .RegWrite(RegWrite), .Read1(Read1), .Read2(Read2),
      .WriteReg(WriteReg), .WriteData(WriteData), .Write(Write), .ALUsrcA(ALUsrcA),
      .ALUsrcB(ALUsrcB), .ALUct1(ALUct1), .Flip(Flip), .OA(OA), .OB(OB), .OC(OC),
      .ALUOut(ALUOut), .Zero(Zero)
   );

   // clock / watchdog
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // reference model
   function automatic logic [15:0] alu_model(input logic [3:0] code, input logic [15:0] l,
                                             input logic [15:0] r);
      case (code)
         4'd0:  return l & r;
         4'd1:  return l | r;
         4'd2:  return l + r;
         4'd3:  return l ^ r;
         4'd4:  return l << r[3:0];
         4'd5:  return l >> r[3:0];
         4'd6:  return l - r;
         4'd7:  return ($signed(l) < $signed(r)) ? 16'h0001 : 16'h0000;
         4'd12: return ~(l | r);
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [15:0] sel_x(input logic [1:0] s, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] c);
      case (s)
         2'd0: return a;
         2'd1: return b;
         2'd2: return c;
         default: return 16'h0001;
      endcase
   endfunction

   function automatic logic [15:0] sel_y(input logic [1:0] s, input logic [15:0] a,
                                         input logic [15:0] c);
      case (s)
         2'd0: return a;
         2'd1: return 16'h0001;
         2'd2: return c;
         default: return 16'h0000;
      endcase
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic write_reg(input logic [3:0] idx, input logic [15:0] val);
      RegWrite = 1'b1; WriteReg = idx; WriteData = val;
      tick();
      RegWrite = 1'b0;
   endtask

   task automatic latch(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] r3);
      Read1 = r1; Read2 = r2; WriteReg = r3; Write = 1'b1;
      tick();
      Write = 1'b0;
   endtask

   task automatic set_alu(input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] op,
                          input logic fl);
      ALUsrcA = sa; ALUsrcB = sb; ALUct1 = op; Flip = fl;
      #1;
   endtask

   // scoreboard
   task automatic push(input string tag, input logic [15:0] v);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic pop_check(input logic [15:0] obs);
      logic [15:0] e;
      string t;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL scoreboard_empty obs=%h exp=none", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", t, obs, e);
         end
      end
   endtask

   task automatic check_alu(input string tag, input logic [15:0] e);
      push({tag, "_out"}, e);
      pop_check(ALUOut);
      push({tag, "_zero"}, {15'd0, (e == 16'h0000)});
      pop_check({15'd0, Zero});
   endtask

   initial begin
      logic [15:0] va, vb, vc, x, y, e;
      logic [1:0]  sa, sb;

      Reset = 1'b1; RegWrite = 1'b0; Read1 = 4'd0; Read2 = 4'd0; WriteReg = 4'd0;
      WriteData = 16'h0; Write = 1'b0; ALUsrcA = 2'd0; ALUsrcB = 2'd0; ALUct1 = 4'd2;
      Flip = 1'b0;
      tick();
      Reset = 1'b0;
      set_alu(2'd0, 2'd0, 4'd2, 1'b0);
      push("rst_oa", 16'h0); pop_check(OA);
      push("rst_ob", 16'h0); pop_check(OB);
      push("rst_oc", 16'h0); pop_check(OC);
      check_alu("rst_add", 16'h0);

      // load and latch
      write_reg(4'd1, 16'd1);
      write_reg(4'd2, 16'd2);
      write_reg(4'd3, 16'd3);
      latch(4'd1, 4'd2, 4'd3);
      Read1 = 4'd3; Read2 = 4'd1; WriteReg = 4'd2;
      tick();
      push("load_oa", 16'd1); pop_check(OA);
      push("load_ob", 16'd2); pop_check(OB);
      push("load_oc", 16'd3); pop_check(OC);

      set_alu(2'd0, 2'd1, 4'd2, 1'b0); check_alu("add", 16'd2);
      set_alu(2'd2, 2'd0, 4'd6, 1'b0); check_alu("sub", 16'd2);
      set_alu(2'd2, 2'd0, 4'd6, 1'b1); check_alu("sub_flip", 16'hFFFE);
      set_alu(2'd0, 2'd2, 4'd7, 1'b1); check_alu("slt_flip", 16'd0);
      set_alu(2'd0, 2'd2, 4'd7, 1'b0); check_alu("slt", 16'd1);
      set_alu(2'd1, 2'd3, 4'd1, 1'b0); check_alu("or_b_zero", 16'd2);
      set_alu(2'd3, 2'd3, 4'd12, 1'b0); check_alu("nor_one_zero", 16'hFFFE);

      // r0 stays zero
      write_reg(4'd0, 16'h1234);
      latch(4'd0, 4'd1, 4'd0);
      push("r0_oa", 16'h0); pop_check(OA);
      push("r0_oc", 16'h0); pop_check(OC);

      // write/read collision on r5
      write_reg(4'd5, 16'h00AA);
      Read1 = 4'd1; Read2 = 4'd2; WriteReg = 4'd5; WriteData = 16'd7;
      RegWrite = 1'b1; Write = 1'b1;
      tick();
      RegWrite = 1'b0; Write = 1'b0;
      push("collide_old", 16'h00AA); pop_check(OC);
      latch(4'd1, 4'd2, 4'd5);
      push("collide_new", 16'd7); pop_check(OC);

      // mid-cycle reset pulse between edges is ignored
      #2 Reset = 1'b1;
      #2;
      push("midrst_oc", 16'd7); pop_check(OC);
      Reset = 1'b0;
      tick();
      push("midrst_edge_oc", 16'd7); pop_check(OC);
      push("midrst_edge_oa", 16'd1); pop_check(OA);

      // randomized operand/op sweep
      for (int round = 0; round < 4; round++) begin
         va = 16'($urandom_range(0, 65535));
         vb = 16'($urandom_range(0, 65535));
         vc = 16'($urandom_range(0, 65535));
         write_reg(4'd4, va);
         write_reg(4'd6, vb);
         write_reg(4'd7, vc);
         latch(4'd4, 4'd6, 4'd7);
         push("rnd_ob", vb); pop_check(OB);
         for (int op = 0; op < 16; op++) begin
            for (int fl = 0; fl < 2; fl++) begin
               sa = 2'($urandom_range(0, 3));
               sb = 2'($urandom_range(0, 3));
               set_alu(sa, sb, 4'(op), fl[0]);
               x = sel_x(sa, va, vb, vc);
               y = sel_y(sb, va, vc);
               e = (fl != 0) ? alu_model(4'(op), y, x) : alu_model(4'(op), x, y);
               check_alu($sformatf("rnd_op%0d_f%0d", op, fl), e);
            end
         end
      end

      // reset wins over RegWrite and Write
      Reset = 1'b1; RegWrite = 1'b1; Write = 1'b1; WriteReg = 4'd3; WriteData = 16'hFFFF;
      Read1 = 4'd4; Read2 = 4'd6;
      tick();
      Reset = 1'b0; RegWrite = 1'b0; Write = 1'b0;
      push("rst2_oa", 16'h0); pop_check(OA);
      push("rst2_ob", 16'h0); pop_check(OB);
      push("rst2_oc", 16'h0); pop_check(OC);
      set_alu(2'd0, 2'd0, 4'd2, 1'b0); check_alu("rst2_add", 16'h0);
      for (int i = 1; i < 16; i += 2) begin
         latch(4'(i), 4'(i + 1), 4'(i + 1));
         push($sformatf("rst2_r%0d", i), 16'h0); pop_check(OA);
         push($sformatf("rst2_r%0d", i + 1), 16'h0); pop_check(OB);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
